// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Central stall / flush / forwarding control for a 5-stage pipeline
//            with configurable load-use latency, memory-busy freeze and a
//            redirect-priority FSM. Define HAZARD_PERF_CNT_EN to build the
//            saturating performance counters.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use1,
  input  logic              d_use2,
  input  logic [REG_AW-1:0] e_rs1,
  input  logic [REG_AW-1:0] e_rs2,
  input  logic [REG_AW-1:0] e_rd,
  input  logic              e_regwrite,
  input  logic              e_is_load,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_regwrite,
  input  logic              m_is_load,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              w_regwrite,
  input  logic              redirect,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              f_d_en,
  output logic              d_e_en,
  output logic              e_m_en,
  output logic              m_w_en,
  output logic              f_d_flush,
  output logic              d_e_flush,
  output logic              m_w_flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic [1:0]        state_o,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush,
  output logic [PERF_W-1:0] perf_memwait
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIR    = 2'd3
  } state_t;

  localparam logic [2:0] c_LU_INIT = 3'(LOAD_LAT - 1);

  // Control vector order: {pc, f_d, d_e, e_m, m_w enables, f_d, d_e, m_w flushes}
  localparam logic [7:0] c_CTL_RUN   = 8'b11111_000;
  localparam logic [7:0] c_CTL_STALL = 8'b00111_010;
  localparam logic [7:0] c_CTL_WAIT  = 8'b00000_001;
  localparam logic [7:0] c_CTL_REDIR = 8'b11111_110;

  state_t     state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic       lu_pend_q, lu_pend_d;
  logic [7:0] ctl_q, ctl_d;
  logic       w_lu;

  always_comb begin
    fwd_sel_a = 2'b00;
    if (e_rs1 != '0) begin
      if (m_regwrite && !m_is_load && (m_rd == e_rs1)) fwd_sel_a = 2'b01;
      else if (w_regwrite && (w_rd == e_rs1))           fwd_sel_a = 2'b10;
    end
  end

  always_comb begin
    fwd_sel_b = 2'b00;
    if (e_rs2 != '0) begin
      if (m_regwrite && !m_is_load && (m_rd == e_rs2)) fwd_sel_b = 2'b01;
      else if (w_regwrite && (w_rd == e_rs2))           fwd_sel_b = 2'b10;
    end
  end

  assign w_lu = e_regwrite && e_is_load && (e_rd != '0) &&
                ((d_use1 && (d_rs1 == e_rd)) || (d_use2 && (d_rs2 == e_rd)));

  // lu_pend marks a stall interrupted by a memory wait with cycles still owed.
  always_comb begin
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    lu_pend_d = lu_pend_q;
    if (mem_busy) begin
      state_d = MEM_WAIT;
      if (state_q == LU_STALL)      lu_pend_d = (lu_cnt_q != 3'd0);
      else if (state_q != MEM_WAIT) lu_pend_d = 1'b0;
    end else if (redirect) begin
      state_d   = REDIR;
      lu_cnt_d  = 3'd0;
      lu_pend_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (w_lu) begin
            state_d  = LU_STALL;
            lu_cnt_d = c_LU_INIT;
          end
        end
        LU_STALL: begin
          if (lu_cnt_q == 3'd0) state_d  = RUN;
          else                  lu_cnt_d = lu_cnt_q - 3'd1;
        end
        MEM_WAIT: begin
          if (lu_pend_q) begin
            state_d   = LU_STALL;
            lu_cnt_d  = lu_cnt_q - 3'd1;
            lu_pend_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    case (state_d)
      LU_STALL: ctl_d = c_CTL_STALL;
      MEM_WAIT: ctl_d = c_CTL_WAIT;
      REDIR:    ctl_d = c_CTL_REDIR;
      default:  ctl_d = c_CTL_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      lu_cnt_q  <= 3'd0;
      lu_pend_q <= 1'b0;
      ctl_q     <= c_CTL_RUN;
    end else begin
      state_q   <= state_d;
      lu_cnt_q  <= lu_cnt_d;
      lu_pend_q <= lu_pend_d;
      ctl_q     <= ctl_d;
    end
  end

  assign {pc_en, f_d_en, d_e_en, e_m_en, m_w_en, f_d_flush, d_e_flush, m_w_flush} = ctl_q;
  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_W-1:0] c_PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] perf_stall_q, perf_flush_q, perf_memwait_q;

  // Counting on the next state keeps each counter in step with state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
      perf_memwait_q <= '0;
    end else begin
      if ((state_d == LU_STALL) && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + c_PERF_ONE;
      if ((state_d == REDIR) && (perf_flush_q != '1))
        perf_flush_q <= perf_flush_q + c_PERF_ONE;
      if ((state_d == MEM_WAIT) && (perf_memwait_q != '1))
        perf_memwait_q <= perf_memwait_q + c_PERF_ONE;
    end
  end

  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
  assign perf_memwait = perf_memwait_q;
`else
  assign perf_stall   = '0;
  assign perf_flush   = '0;
  assign perf_memwait = '0;
`endif

endmodule
`default_nettype wire
